// File: rtl/fifo_stream_reader.sv
// Read-side engine for a registered-read FIFO: issues pops, captures the
// returned words into a head/skid buffer and presents them as a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_nxt;
  logic                  pend;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] skid_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  pop;
  logic                  cap;
  logic [2:0]            occ;

  assign m_valid  = (buf_cnt != 2'd0);
  assign m_data   = head;
  assign word_cnt = cnt;

  // Issue decision: occupancy counts the in-flight word so the buffer can never overflow
  always_comb begin
    pop     = (buf_cnt != 2'd0) & m_ready;
    cap     = pend & ~flush;
    occ     = {1'b0, buf_cnt} + {2'b00, pend} - {2'b00, pop};
    fifo_rd = ~reset & ~flush & ~fifo_empty & (occ <= 3'd1);
  end

  // Buffer update: the arriving word goes to head only if the buffer is empty after this pop
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    head_nxt    = head;
    skid_nxt    = skid;
    if (flush) begin
      buf_cnt_nxt = 2'd0;
    end else begin
      buf_cnt_nxt = buf_cnt + {1'b0, cap} - {1'b0, pop};
    end
    if (pop && (buf_cnt == 2'd2)) begin
      head_nxt = skid;
    end else begin
      head_nxt = head;
    end
    if (cap) begin
      if (buf_cnt == {1'b0, pop}) begin
        head_nxt = fifo_rdata;
      end else begin
        skid_nxt = fifo_rdata;
      end
    end else begin
      skid_nxt = skid;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_cnt <= 2'd0;
      pend    <= 1'b0;
      head    <= {DATA_WIDTH{1'b0}};
      skid    <= {DATA_WIDTH{1'b0}};
      cnt     <= {CNT_WIDTH{1'b0}};
    end else begin
      buf_cnt <= buf_cnt_nxt;
      pend    <= fifo_rd;
      head    <= head_nxt;
      skid    <= skid_nxt;
      if (pop) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: registered-read FIFO model plus
// a scoreboard of pushed words compared against stream handshakes.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rdata = '0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_cnt;

  logic          hold = 1'b1;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] fifo_q[$];
  int            fifo_n = 0;

  logic [DW-1:0] exp_q[$];
  int            issued = 0;
  int            delivered = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  assign fifo_empty = hold | (fifo_n == 0);

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    push_en   = 1'b1;
    push_data = w;
    next_cycle();
    push_en   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < budget) begin
      next_cycle();
      k++;
    end
    check("drain_done", (k < budget) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // FIFO model with registered read port
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        fifo_q.delete();
        fifo_n <= 0;
      end else begin
        if (fifo_rd) begin
          if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
          else fifo_rdata <= 8'hEE;
        end
        if (push_en) fifo_q.push_back(push_data);
        fifo_n <= fifo_q.size();
      end
    end
  end

  // Scoreboard / monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        issued     = 0;
        delivered  = 0;
        prev_stall = 1'b0;
      end else begin
        if (push_en) exp_q.push_back(push_data);
        check("rd_on_empty", {31'd0, fifo_rd & fifo_empty}, 0);
        if (m_valid && prev_stall) check("stall_hold", m_data, prev_data);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) check("extra_word", m_data, 32'hFFFF_FFFF);
          else check("data", m_data, exp_q.pop_front());
          delivered++;
        end
        if (flush) begin
          for (int d = 0; d < issued - delivered; d++) begin
            if (exp_q.size() > 0) exp_q.delete(0);
          end
          delivered = issued;
        end
        if (fifo_rd) issued++;
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
      end
    end
  end

  initial begin
    #100000;
    check("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int base;
    int rd_cnt;
    int rd_at;
    int v_at;

    // Reset state
    #2;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_rd", fifo_rd, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Preloaded FIFO, downstream always ready
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    hold    = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_rd", fifo_rd, (i <= 2) ? 1 : 0);
      check("t1_valid", m_valid, (i >= 2 && i <= 4) ? 1 : 0);
      next_cycle();
    end
    check("t1_cnt", word_cnt, 3);
    check("t1_sb_empty", exp_q.size(), 0);

    // Back-pressure
    m_ready = 1'b0;
    hold    = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h40 + DW'(i));
    base = issued;
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      next_cycle();
    end
    check("bp_pulses", issued - base, 2);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 8'h40);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_no_gap", m_valid, 1);
      next_cycle();
    end
    @(negedge clk);
    check("bp_done_valid", m_valid, 0);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_cnt", word_cnt, 8);
    next_cycle();

    // Empty FIFO boundary, then a single word
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("empty_rd", fifo_rd, 0);
      check("empty_valid", m_valid, 0);
      next_cycle();
    end
    rd_cnt    = 0;
    rd_at     = -1;
    v_at      = -1;
    push_en   = 1'b1;
    push_data = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      push_en = 1'b0;
      @(negedge clk);
      if (fifo_rd) begin
        rd_cnt++;
        if (rd_at < 0) rd_at = i;
      end
      if (m_valid && v_at < 0) v_at = i;
    end
    next_cycle();
    check("single_rd_once", rd_cnt, 1);
    check("single_rd_at", rd_at, 0);
    check("single_latency", v_at - rd_at, 2);
    check("single_cnt", word_cnt, 9);

    // Flush with one buffered and one in-flight word
    m_ready = 1'b0;
    hold    = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'h60 + DW'(i));
    hold = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    flush   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("flush_rd", fifo_rd, 0);
    check("flush_valid_before", m_valid, 1);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid_after", m_valid, 0);
    drain(40);
    check("flush_cnt", word_cnt, 14);

    // Counter wrap: 17 handshakes from reset
    do_reset();
    for (int i = 0; i < 17; i++) push_word(8'h80 + DW'(i));
    drain(60);
    check("wrap_cnt", word_cnt, 1);

    // Asynchronous reset mid-stream
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'hC0 + DW'(i));
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      next_cycle();
    end
    check("mid_valid_pre", m_valid, 1);
    check("mid_rd_pre", fifo_rd, 1);
    check("mid_cnt_pre", word_cnt, 1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_cnt", word_cnt, 0);
    check("arst_rd", fifo_rd, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_word(8'hD1);
    push_word(8'hD2);
    push_word(8'hD3);
    drain(40);
    check("post_rst_cnt", word_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side engine for the block-RAM FIFO variant, whose read port is registered: data appears one cycle after the pop.
- Issues pops (fifo_rd) into the FIFO controller's rd/empty interface and captures the returned words into a 2-entry output buffer.
- Presents the words as a valid/ready stream (first-word-fall-through) at 1 word/cycle sustained.
- Sits between the FIFO and downstream consumers (UART TX, DMA sink).

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
CNT_WIDTH, 16, width of delivered-word counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_rd  output  1  pop request to FIFO (one word per high cycle)
fifo_rdata  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd was high
flush  input  1  synchronous discard of all buffered and in-flight words
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  stream data (head of buffer)
word_cnt  output  CNT_WIDTH  count of words delivered (handshakes)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high; all registers clear immediately on assertion.
- Reset values:
  - m_valid=0, m_data=0, word_cnt=0, buffer count buf_cnt=0.
  - In-flight flag pend=0.
  - fifo_rd forced 0 while reset is high.
- State:
  - buf_cnt: 0..2 entries.
  - head/skid data registers.
  - pend: registered copy of the previous cycle's fifo_rd.
- Pop handshake: pop = m_valid & m_ready.
  - m_valid = (buf_cnt != 0).
  - m_data = head register.
  - Data must not change while m_valid=1 and m_ready=0.
- Issue rule (combinational):
  - fifo_rd = ~reset & ~flush & ~fifo_empty & ((buf_cnt + pend − pop) <= 1).
  - This guarantees no buffer overflow, and that no pop is issued to an empty FIFO.
- Capture: when pend=1 (and no flush), fifo_rdata is written this cycle.
  - Write to head if the buffer becomes empty after pop; otherwise write to skid.
  - On pop with skid valid, skid moves to head.
- Latency and throughput:
  - Non-empty FIFO, idle buffer: fifo_rd in cycle N, m_valid=1 from cycle N+2.
  - Steady state with m_ready=1: one word per cycle, fifo_rd held high continuously.
- Simultaneous capture and pop in one cycle:
  - buf_cnt unchanged.
  - Ordering is preserved: head ← skid or new word, strictly FIFO order.
- Back-pressure:
  - m_ready=0 fills the buffer to 2 (including the in-flight word), then fifo_rd=0 until a pop frees space.
  - No word is lost or duplicated.
- Flush:
  - In the flush cycle: fifo_rd=0; buf_cnt←0; any word arriving this cycle (pend=1) is discarded.
  - Next cycle: pend=0, m_valid=0.
  - A handshake coinciding with flush still counts (word delivered).
  - word_cnt is not cleared by flush.
- word_cnt:
  - Increments by 1 per pop.
  - Wraps 2^CNT_WIDTH−1 → 0 without a flag.
- fifo_empty toggling: sampled only in the issue cycle. Words already in flight are always captured unless flushed.
- Reset mid-transfer: buffered and in-flight words are lost. The FIFO is reset by the same reset, so no stale return data arrives.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33, m_ready=1:
  - fifo_rd high on cycles 0–2.
  - m_valid from cycle 2.
  - m_data 0x11,0x22,0x33 on consecutive cycles.
  - word_cnt=3, then m_valid=0.
- Back-pressure: FIFO holds 5 words, m_ready=0 for 6 cycles:
  - exactly 2 fifo_rd pulses; buf_cnt=2; m_data stable at first word.
  - Then m_ready=1: all 5 delivered in order, no gaps after the first.
- Empty boundary: FIFO empty:
  - fifo_rd never asserts; m_valid=0.
  - Write one word 0xA5: delivered 2 cycles after its fifo_rd; fifo_rd asserts once only.
- Flush with pend=1 and buf_cnt=1:
  - next cycle m_valid=0; fifo_rd=0 during flush.
  - Subsequent words resume in order from the next FIFO entry; the discarded words never appear.
- Counter wrap, CNT_WIDTH=4: 17 handshakes → word_cnt=1.
- Async reset mid-stream (between clock edges): m_valid, word_cnt and fifo_rd drop to 0 immediately. After release, normal operation resumes.
